// File: rtl/atm_pkg.sv
// Shared ATM constants: op codes, controller states and default field widths.
package atm_pkg;
  localparam int CARD_WIDTH    = 3;
  localparam int PSW_WIDTH     = 4;
  localparam int BALANCE_WIDTH = 20;

  localparam logic [1:0] OP_INQUIRY  = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;
  localparam logic [1:0] OP_END      = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT1,
    WAIT2,
    READY,
    EXEC,
    LOCKED
  } state_e;
endpackage

// File: rtl/transaction_ctrl_if.sv
// Bundle between the transaction controller and the card-handling side.
// slave is the controller's view; master is the card-handling/host view.
interface transaction_ctrl_if #(
  parameter int balance_width = atm_pkg::BALANCE_WIDTH
) ();
  logic                     card_in;
  logic                     psw_enter;
  logic                     wrong_psw;
  logic [balance_width-1:0] balance;
  logic                     op_valid;
  logic [1:0]               op_code;
  logic [balance_width-1:0] amount;
  logic                     op_ready;
  logic [balance_width-1:0] updated_balance;
  logic                     op_done;
  logic                     insufficient;
  logic                     overflow;
  logic                     card_locked;
  logic                     eject;

  modport slave (
    input  card_in, psw_enter, wrong_psw, balance, op_valid, op_code, amount,
    output op_ready, updated_balance, op_done, insufficient, overflow,
           card_locked, eject
  );

  modport master (
    output card_in, psw_enter, wrong_psw, balance, op_valid, op_code, amount,
    input  op_ready, updated_balance, op_done, insufficient, overflow,
           card_locked, eject
  );
endinterface

// File: rtl/atm_session_timer.sv
// Idle-session counter: counts while enabled, expired is high on the last allowed cycle.
// clear has priority over enable and also serves as the reset path.
module atm_session_timer #(
  parameter int timeout_cycles = 1024
) (
  input  logic clk,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == CW'(timeout_cycles - 1));
endmodule

// File: rtl/transaction_ctrl.sv
// ATM session controller: PIN check, then inquiry/deposit/withdraw with op_done 2 cycles after accept.
// op_ready is high only in READY; all other outputs are registered.
module transaction_ctrl
  import atm_pkg::*;
#(
  parameter int balance_width  = BALANCE_WIDTH,
  parameter int max_tries      = 3,
  parameter int timeout_cycles = 1024
) (
  input logic               clk,
  input logic               rst,
  transaction_ctrl_if.slave bus
);
  localparam int TW = $clog2(max_tries + 1);
  localparam logic [TW-1:0] MAX_T = TW'(max_tries);

  state_e                   state_q, state_d;
  logic [TW-1:0]            tries_q, tries_d;
  logic [balance_width-1:0] bal_q, bal_d;
  logic [balance_width-1:0] amt_q, amt_d;
  logic [1:0]               op_q, op_d;
  logic                     done_q, done_d;
  logic                     ins_q, ins_d;
  logic                     ovf_q, ovf_d;
  logic                     ej_q, ej_d;
  logic                     lock_q, lock_d;
  logic                     accept, expired, tmr_en, tmr_clr;
  logic [balance_width:0]   sum;

  assign accept  = bus.op_valid && (state_q == READY) && bus.card_in;
  assign tmr_en  = (state_q == READY) && bus.card_in;
  assign tmr_clr = rst || accept || !tmr_en;
  assign sum     = {1'b0, bal_q} + {1'b0, amt_q};

  atm_session_timer #(.timeout_cycles(timeout_cycles)) u_timer (
    .clk    (clk),
    .enable (tmr_en),
    .clear  (tmr_clr),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    bal_d   = bal_q;
    amt_d   = amt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    ins_d   = 1'b0;
    ovf_d   = 1'b0;
    ej_d    = 1'b0;
    // A missing card aborts whatever is in flight and forgets failed attempts.
    if (!bus.card_in) begin
      state_d = IDLE;
      tries_d = '0;
    end else begin
      case (state_q)
        IDLE:   if (bus.psw_enter) state_d = WAIT1;
        WAIT1:  state_d = WAIT2;
        WAIT2: begin
          if (!bus.wrong_psw) begin
            bal_d   = bus.balance;
            tries_d = '0;
            state_d = READY;
          end else begin
            tries_d = tries_q + TW'(1);
            state_d = (tries_d >= MAX_T) ? LOCKED : IDLE;
          end
        end
        READY: begin
          if (bus.op_valid) begin
            if (bus.op_code == OP_END) begin
              ej_d    = 1'b1;
              state_d = IDLE;
            end else begin
              op_d    = bus.op_code;
              amt_d   = bus.amount;
              state_d = EXEC;
            end
          end else if (expired) begin
            ej_d    = 1'b1;
            state_d = IDLE;
          end
        end
        EXEC: begin
          state_d = READY;
          done_d  = 1'b1;
          case (op_q)
            OP_DEPOSIT: begin
              if (sum[balance_width]) ovf_d = 1'b1;
              else                    bal_d = sum[balance_width-1:0];
            end
            OP_WITHDRAW: begin
              if (amt_q > bal_q) ins_d = 1'b1;
              else               bal_d = bal_q - amt_q;
            end
            default: ;
          endcase
        end
        LOCKED:  ;
        default: state_d = IDLE;
      endcase
    end
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tries_q <= '0;
      bal_q   <= '0;
      amt_q   <= '0;
      op_q    <= OP_INQUIRY;
      done_q  <= 1'b0;
      ins_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ej_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      bal_q   <= bal_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      done_q  <= done_d;
      ins_q   <= ins_d;
      ovf_q   <= ovf_d;
      ej_q    <= ej_d;
      lock_q  <= lock_d;
    end
  end

  assign bus.op_ready        = (state_q == READY);
  assign bus.updated_balance = bal_q;
  assign bus.op_done         = done_q;
  assign bus.insufficient    = ins_q;
  assign bus.overflow        = ovf_q;
  assign bus.card_locked     = lock_q;
  assign bus.eject           = ej_q;
endmodule

// File: tb/tb_transaction_ctrl.sv
// Bench for transaction_ctrl: session-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_transaction_ctrl;
  localparam int BW   = 20;
  localparam int MAXT = 3;
  localparam int TO   = 16;
  localparam int MAXB = (1 << BW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  transaction_ctrl_if #(.balance_width(BW)) bus ();

  transaction_ctrl #(.balance_width(BW), .max_tries(MAXT), .timeout_cycles(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: card/PIN progress, authenticated session, one pending operation.
  bit model_on = 0;
  int m_bal, m_tries, m_pin, m_idle, m_op, m_amt;
  bit m_locked, m_auth, m_exec;
  bit m_done, m_ins, m_ovf, m_ej;

  always @(posedge clk) begin
    m_done = 0; m_ins = 0; m_ovf = 0; m_ej = 0;
    if (rst) begin
      model_on = 1;
      m_bal = 0; m_tries = 0; m_pin = 0; m_idle = 0;
      m_locked = 0; m_auth = 0; m_exec = 0;
    end else if (!bus.card_in) begin
      m_tries = 0; m_pin = 0; m_idle = 0;
      m_locked = 0; m_auth = 0; m_exec = 0;
    end else if (m_locked) begin
      m_locked = 1;
    end else if (m_pin == 2) begin
      m_pin = 1;
    end else if (m_pin == 1) begin
      m_pin = 0;
      if (!bus.wrong_psw) begin
        m_bal = int'(bus.balance); m_tries = 0; m_auth = 1; m_idle = 0;
      end else begin
        m_tries++;
        if (m_tries >= MAXT) m_locked = 1;
      end
    end else if (m_exec) begin
      m_exec = 0; m_done = 1;
      if (m_op == 1) begin
        if (m_bal + m_amt > MAXB) m_ovf = 1;
        else m_bal = m_bal + m_amt;
      end else if (m_op == 2) begin
        if (m_amt > m_bal) m_ins = 1;
        else m_bal = m_bal - m_amt;
      end
    end else if (m_auth) begin
      if (bus.op_valid) begin
        m_idle = 0;
        if (bus.op_code == 2'd3) begin
          m_ej = 1; m_auth = 0;
        end else begin
          m_exec = 1; m_op = int'(bus.op_code); m_amt = int'(bus.amount);
        end
      end else if (m_idle == TO - 1) begin
        m_ej = 1; m_auth = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end else if (bus.psw_enter) begin
      m_pin = 2;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("op_ready", 32'(bus.op_ready), 32'(m_auth && !m_exec));
      chk("updated_balance", 32'(bus.updated_balance), 32'(m_bal));
      chk("op_done", 32'(bus.op_done), 32'(m_done));
      chk("insufficient", 32'(bus.insufficient), 32'(m_ins));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("card_locked", 32'(bus.card_locked), 32'(m_locked));
      chk("eject", 32'(bus.eject), 32'(m_ej));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.op_ready), 0);
    chk({tag, "_bal"}, 32'(bus.updated_balance), 0);
    chk({tag, "_done"}, 32'(bus.op_done), 0);
    chk({tag, "_ins"}, 32'(bus.insufficient), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    chk({tag, "_lock"}, 32'(bus.card_locked), 0);
    chk({tag, "_eject"}, 32'(bus.eject), 0);
  endtask

  task automatic login(input int bal, input bit wrong);
    bus.card_in = 1; bus.psw_enter = 1;
    bus.balance = BW'(bal); bus.wrong_psw = wrong;
    cyc();
    bus.psw_enter = 0;
    cyc();
    cyc();
  endtask

  task automatic op(input logic [1:0] code, input int amt);
    bus.op_valid = 1; bus.op_code = code; bus.amount = BW'(amt);
    cyc();
    bus.op_valid = 0;
    chk("exec_no_done", 32'(bus.op_done), 0);
    cyc();
  endtask

  task automatic end_session();
    bus.op_valid = 1; bus.op_code = 2'd3;
    cyc();
    bus.op_valid = 0;
    chk("end_eject", 32'(bus.eject), 1);
    chk("end_done", 32'(bus.op_done), 0);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 1000));
      1: return MAXB - int'($urandom_range(0, 1000));
      2: return int'($urandom & MAXB);
      default: return 0;
    endcase
  endfunction

  initial begin
    rst = 1;
    bus.card_in = 0; bus.psw_enter = 0; bus.wrong_psw = 0; bus.balance = '0;
    bus.op_valid = 0; bus.op_code = 2'd0; bus.amount = '0;
    cyc();
    cyc();
    all_zero("reset");
    rst = 0;

    login(500, 0);
    chk("login_ready", 32'(bus.op_ready), 1);
    chk("login_bal", 32'(bus.updated_balance), 500);
    op(2'd1, 250);
    chk("dep_done", 32'(bus.op_done), 1);
    chk("dep_bal", 32'(bus.updated_balance), 750);
    end_session();

    login(100, 0);
    op(2'd2, 101);
    chk("wd101_ins", 32'(bus.insufficient), 1);
    chk("wd101_done", 32'(bus.op_done), 1);
    chk("wd101_bal", 32'(bus.updated_balance), 100);
    op(2'd2, 100);
    chk("wd100_ins", 32'(bus.insufficient), 0);
    chk("wd100_bal", 32'(bus.updated_balance), 0);
    op(2'd0, 0);
    chk("inq_done", 32'(bus.op_done), 1);
    end_session();

    login(MAXB, 0);
    op(2'd1, 1);
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_bal", 32'(bus.updated_balance), 1048575);
    op(2'd1, 0);
    chk("dep0_done", 32'(bus.op_done), 1);
    chk("dep0_ovf", 32'(bus.overflow), 0);
    op(2'd2, 5);
    op(2'd1, 5);
    chk("exact_max_ovf", 32'(bus.overflow), 0);
    chk("exact_max_bal", 32'(bus.updated_balance), 1048575);
    end_session();

    login(7, 1);
    chk("try1_lock", 32'(bus.card_locked), 0);
    login(7, 1);
    chk("try2_lock", 32'(bus.card_locked), 0);
    login(7, 1);
    chk("try3_lock", 32'(bus.card_locked), 1);
    bus.op_valid = 1; bus.op_code = 2'd2; bus.amount = BW'(1); bus.psw_enter = 1;
    cyc();
    cyc();
    chk("locked_ready", 32'(bus.op_ready), 0);
    chk("locked_done", 32'(bus.op_done), 0);
    chk("locked_hold", 32'(bus.card_locked), 1);
    bus.op_valid = 0; bus.psw_enter = 0; bus.card_in = 0;
    cyc();
    chk("unlock", 32'(bus.card_locked), 0);
    login(7, 1);
    login(7, 1);
    chk("fresh_tries_lock", 32'(bus.card_locked), 0);
    login(42, 0);
    chk("fresh_ready", 32'(bus.op_ready), 1);
    chk("fresh_bal", 32'(bus.updated_balance), 42);

    for (int i = 0; i < TO - 1; i++) begin
      cyc();
      chk("to_wait_eject", 32'(bus.eject), 0);
    end
    cyc();
    chk("to_eject", 32'(bus.eject), 1);
    chk("to_ready", 32'(bus.op_ready), 0);
    cyc();
    chk("to_eject_pulse", 32'(bus.eject), 0);

    login(300, 0);
    bus.op_valid = 1; bus.op_code = 2'd2; bus.amount = BW'(50);
    cyc();
    bus.op_valid = 0; bus.card_in = 0;
    cyc();
    chk("abort_done", 32'(bus.op_done), 0);
    chk("abort_bal", 32'(bus.updated_balance), 300);
    login(300, 0);
    bus.op_valid = 1; bus.op_code = 2'd2; bus.amount = BW'(50);
    cyc();
    bus.op_valid = 0; rst = 1;
    cyc();
    all_zero("rst_exec");
    rst = 0;

    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.card_in   = ($urandom_range(0, 39) != 0);
      bus.psw_enter = ($urandom_range(0, 3) == 0);
      bus.wrong_psw = ($urandom_range(0, 2) == 0);
      bus.op_valid  = 1'($urandom_range(0, 1));
      bus.op_code   = 2'($urandom_range(0, 3));
      bus.balance   = BW'(pick());
      bus.amount    = BW'(pick());
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
